// File: rtl/paddle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : paddle_ctrl
//  Description : Two-player paddle controller. Synchronizes and debounces
//                four raw push buttons, detects the rising edge of the frame
//                marker and moves each paddle by STEP lines per frame,
//                saturating at the top and bottom of the playfield.
//  Revision    : 1.0 - initial release
// ============================================================================
module paddle_ctrl #(
  parameter int SCREEN_H   = 480,
  parameter int PADDLE_H   = 64,
  parameter int STEP       = 4,
  parameter int DEB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left_up,
  input  logic       left_down,
  input  logic       right_up,
  input  logic       right_down,
  input  logic       frame_tick,
  output logic [3:0] btn,
  output logic [9:0] left_pos,
  output logic [9:0] right_pos
);

  // Debounce counter sized to hold DEB_CYCLES-1.
  localparam int            CW           = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] C_DEB_LAST   = CW'(DEB_CYCLES - 1);

  // Paddle travel limits: top line ranges over 0 .. SCREEN_H-PADDLE_H.
  localparam logic [9:0]    C_POS_MAX    = 10'(SCREEN_H - PADDLE_H);
  localparam logic [9:0]    C_POS_RST    = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [9:0]    C_STEP       = 10'(STEP);
  localparam logic [9:0]    C_DOWN_LIMIT = 10'(SCREEN_H - PADDLE_H - STEP);

  // Raw buttons gathered in the same bit order as the debounced output.
  logic [3:0] w_raw;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_btn;
  logic       r_ft_d;
  logic       w_move;
  logic [9:0] w_left_nxt;
  logic [9:0] w_right_nxt;

  assign w_raw = {right_down, right_up, left_down, left_up};

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // One debouncer per button: the level is accepted only after the
  // synchronized value has disagreed with it for DEB_CYCLES straight cycles.
  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [CW-1:0] r_cnt;
    logic          r_deb;

    // Count consecutive disagreeing cycles; flip and restart on the last one.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
        r_deb <= 1'b0;
      end else if (r_sync2[i] == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == C_DEB_LAST) begin
        r_deb <= r_sync2[i];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end

    assign w_btn[i] = r_deb;
  end

  assign btn = w_btn;

  // Delayed copy of the frame marker for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ft_d <= 1'b0;
    end else begin
      r_ft_d <= frame_tick;
    end
  end

  // A long high frame marker still yields a single move.
  assign w_move = frame_tick & ~r_ft_d;

  // Saturating one-step move; conflicting or idle buttons leave it in place.
  function automatic logic [9:0] f_step(input logic [9:0] pos,
                                        input logic       up,
                                        input logic       down);
    logic [9:0] res;
    res = pos;
    if (up && !down) begin
      res = (pos < C_STEP) ? 10'd0 : pos - C_STEP;
    end else if (down && !up) begin
      res = (pos > C_DOWN_LIMIT) ? C_POS_MAX : pos + C_STEP;
    end
    return res;
  endfunction

  // Next paddle positions; only a move event lets them change.
  always_comb begin
    w_left_nxt  = left_pos;
    w_right_nxt = right_pos;
    if (w_move) begin
      w_left_nxt  = f_step(left_pos,  w_btn[0], w_btn[1]);
      w_right_nxt = f_step(right_pos, w_btn[2], w_btn[3]);
    end
  end

  // Paddle position registers, centred on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_pos  <= C_POS_RST;
      right_pos <= C_POS_RST;
    end else begin
      left_pos  <= w_left_nxt;
      right_pos <= w_right_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_paddle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_paddle_ctrl
//  Description : Self-checking bench for paddle_ctrl (DEB_CYCLES = 4).
//                Directed table, hand-written reset sequences and a random
//                phase checked against a window-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_paddle_ctrl;

  localparam int DEB   = 4;
  localparam int STEPV = 4;
  localparam int PMAX  = 480 - 64;
  localparam int PMID  = (480 - 64) / 2;

  logic       clk;
  logic       rst;
  logic       left_up, left_down, right_up, right_down;
  logic       frame_tick;
  logic [3:0] btn;
  logic [9:0] left_pos, right_pos;

  int n_vec;
  int n_err;

  paddle_ctrl #(
    .SCREEN_H  (480),
    .PADDLE_H  (64),
    .STEP      (STEPV),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .left_up   (left_up),
    .left_down (left_down),
    .right_up  (right_up),
    .right_down(right_down),
    .frame_tick(frame_tick),
    .btn       (btn),
    .left_pos  (left_pos),
    .right_pos (right_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: raw samples per edge since reset, debounced
  // levels, paddle positions and the frame marker seen on the previous edge.
  bit [3:0] rq[$];
  bit [3:0] mbtn;
  int       ml, mr;
  bit       mft_prev;

  task automatic model_reset();
    rq.delete();
    mbtn     = 4'b0000;
    ml       = PMID;
    mr       = PMID;
    mft_prev = 1'b0;
  endtask

  function automatic int npos(input int p, input bit up, input bit down);
    if (up && !down)  return (p - STEPV < 0) ? 0 : p - STEPV;
    if (down && !up)  return (p + STEPV > PMAX) ? PMAX : p + STEPV;
    return p;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic set_raw(input logic [3:0] r);
    {right_down, right_up, left_down, left_up} = r;
  endtask

  // One clock: capture inputs, advance the model, compare #1 after the edge.
  task automatic cycle();
    bit [3:0] r_now;
    bit [3:0] nb;
    bit [3:0] smp;
    bit       ft_now, mv, all_diff;
    int       k, j;
    r_now  = {right_down, right_up, left_down, left_up};
    ft_now = frame_tick;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      rq.push_back(r_now);
      k  = rq.size();
      mv = ft_now && !mft_prev;
      if (mv) begin
        ml = npos(ml, mbtn[0], mbtn[1]);
        mr = npos(mr, mbtn[2], mbtn[3]);
      end
      // A button flips once its last DEB synchronized samples (raw delayed
      // by two edges) all disagree with the current debounced level.
      nb = mbtn;
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        for (int d = 0; d < DEB; d++) begin
          j   = k - 2 - d;
          smp = (j >= 1) ? rq[j-1] : 4'b0000;
          if (smp[i] == mbtn[i]) all_diff = 1'b0;
        end
        if (all_diff) nb[i] = ~mbtn[i];
      end
      mbtn     = nb;
      mft_prev = ft_now;
    end
    #1;
    check("model_btn",   btn,       mbtn);
    check("model_left",  left_pos,  ml);
    check("model_right", right_pos, mr);
  endtask

  // Assert reset between edges, check its immediate effect, release later.
  task automatic async_reset(input int held);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_btn",   btn,       4'b0000);
    check("async_rst_left",  left_pos,  PMID);
    check("async_rst_right", right_pos, PMID);
    repeat (held) cycle();
    #2 rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] raw;
    int         hold;
    int         pulses;
    int         ft_high;
    logic [3:0] exp_btn;
    int         exp_l;
    int         exp_r;
  } vec_t;

  localparam int NT = 9;
  vec_t  tbl[NT];
  string tname[NT];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] cur;
    n_vec = 0;
    n_err = 0;

    //                raw     hold pulses fthi  btn      left  right
    tbl[0] = '{4'b0001,   3,    0,   0, 4'b0000, PMID, PMID}; tname[0] = "short_glitch";
    tbl[1] = '{4'b0000,  10,   20,   0, 4'b0000, PMID, PMID}; tname[1] = "glitch_no_move";
    tbl[2] = '{4'b0001,   6,    0,   0, 4'b0001, PMID, PMID}; tname[2] = "lu_latency";
    tbl[3] = '{4'b0001,   0,   10,   0, 4'b0001,  168, PMID}; tname[3] = "lu_10_steps";
    tbl[4] = '{4'b1000,   6,  110,   0, 4'b1000,  168, PMAX}; tname[4] = "rd_saturate";
    tbl[5] = '{4'b1001,   6,   60,   0, 4'b1001,    0, PMAX}; tname[5] = "lu_saturate";
    tbl[6] = '{4'b0010,   6,   10,   0, 4'b0010,   40, PMAX}; tname[6] = "ld_10_steps";
    tbl[7] = '{4'b0011,   6,    5,   0, 4'b0011,   40, PMAX}; tname[7] = "both_hold";
    tbl[8] = '{4'b0001,   6,    0,  50, 4'b0001,   36, PMAX}; tname[8] = "ft_held_once";

    // Reset before any clock edge.
    rst = 1'b1;
    set_raw(4'b0000);
    frame_tick = 1'b0;
    #2;
    check("por_btn",   btn,       4'b0000);
    check("por_left",  left_pos,  PMID);
    check("por_right", right_pos, PMID);
    model_reset();
    cycle();
    cycle();
    #2 rst = 1'b0;

    // Directed table.
    for (int e = 0; e < NT; e++) begin
      set_raw(tbl[e].raw);
      frame_tick = 1'b0;
      repeat (tbl[e].hold) cycle();
      for (int p = 0; p < tbl[e].pulses; p++) begin
        frame_tick = 1'b1; cycle();
        frame_tick = 1'b0; cycle();
      end
      if (tbl[e].ft_high > 0) begin
        frame_tick = 1'b1;
        repeat (tbl[e].ft_high) cycle();
        frame_tick = 1'b0;
        cycle();
      end
      check({tname[e], "_btn"},   btn,       tbl[e].exp_btn);
      check({tname[e], "_left"},  left_pos,  tbl[e].exp_l);
      check({tname[e], "_right"}, right_pos, tbl[e].exp_r);
    end

    // Reset during movement, then movement only after a fresh debounce.
    set_raw(4'b0001);
    for (int p = 0; p < 2; p++) begin
      frame_tick = 1'b1; cycle();
      frame_tick = 1'b0; cycle();
    end
    frame_tick = 1'b1;
    cycle();
    check("pre_rst_left", left_pos, 24);
    async_reset(2);
    for (int c = 0; c < 6; c++) begin
      frame_tick = (c % 2 == 0);
      cycle();
    end
    check("redeb_btn",  btn,      4'b0001);
    check("redeb_left", left_pos, PMID);
    frame_tick = 1'b1; cycle();
    check("resume_left", left_pos, PMID - STEPV);
    frame_tick = 1'b0; cycle();

    // Randomized phase against the reference model.
    cur = 4'b0000;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0) async_reset(int'($urandom_range(0, 2)));
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 9) == 0) cur[i] = ~cur[i];
      set_raw(cur);
      frame_tick = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/paddle_ctrl.md
PADDLE_CTRL -- requirements
Module: paddle_ctrl

Interface
REQ-001 SHALL have parameter SCREEN_H, default 480, visible lines in the playfield.
REQ-002 SHALL have parameter PADDLE_H, default 64, paddle height in lines; PADDLE_H < SCREEN_H.
REQ-003 SHALL have parameter STEP, default 4, lines moved per frame event; 1 <= STEP <= SCREEN_H-PADDLE_H.
REQ-004 SHALL have parameter DEB_CYCLES, default 250000, debounce hold time in clk cycles (10 ms at 25 MHz); DEB_CYCLES >= 2; counter width = clog2(DEB_CYCLES).
REQ-005 SHALL have port clk  input  1  pixel clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-007 SHALL have port left_up, left_down, right_up, right_down  input  1 each  raw, asynchronous, active-high push buttons.
REQ-008 SHALL have port frame_tick  input  1  frame marker from the VGA timing stage; only its rising edge is significant.
REQ-009 SHALL have port btn  output  4  debounced buttons, bit order {right_down, right_up, left_down, left_up}.
REQ-010 SHALL have port left_pos  output  10  top line of left paddle, registered.
REQ-011 SHALL have port right_pos  output  10  top line of right paddle, registered.

Function
REQ-012 Each raw button SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Per button: a counter SHALL clear whenever the synchronized value equals the debounced value, and otherwise increment by 1 each cycle.
REQ-014 When the synchronized value differs from the debounced value and the counter equals DEB_CYCLES-1, the debounced value SHALL take the synchronized value and the counter SHALL clear on the same edge.
REQ-015 Latency: a raw change held stable SHALL appear on btn on the (DEB_CYCLES+2)th rising edge, counting the first edge that samples it.
REQ-016 Any raw pulse shorter than DEB_CYCLES cycles after synchronization SHALL leave btn unchanged.
REQ-017 A one-cycle registered copy of frame_tick SHALL be kept; a move event occurs on the cycle where frame_tick=1 and its copy=0.
REQ-018 On a move event, with up/down taken from btn (debounced) in that same cycle, each paddle SHALL update independently on that edge.
REQ-019 up=1, down=0: pos <= (pos < STEP) ? 0 : pos-STEP; no underflow wrap.
REQ-020 down=1, up=0: pos <= (pos > SCREEN_H-PADDLE_H-STEP) ? SCREEN_H-PADDLE_H : pos+STEP; no overflow wrap.
REQ-021 Both up and down set, or neither set: pos SHALL hold.
REQ-022 Without a move event, positions SHALL hold regardless of btn.
REQ-023 frame_tick held high for many cycles SHALL produce exactly one move event.
REQ-024 Positions SHALL always satisfy 0 <= pos <= SCREEN_H-PADDLE_H.

Reset
REQ-025 While rst=1, without waiting for clk: synchronizer flops, debounced btn, counters and frame_tick copy SHALL be 0; left_pos = right_pos = (SCREEN_H-PADDLE_H)/2 (208 at defaults).
REQ-026 rst asserted mid-debounce or mid-move SHALL discard all pending state; there is no partial update.
REQ-027 If frame_tick=1 on the first edge after rst release, that edge SHALL count as a move event (copy resets to 0).

Verification (DEB_CYCLES=4, others default)
REQ-028 Assert rst, no clk edge -> left_pos=208, right_pos=208, btn=0000 immediately.
REQ-029 left_up=1 for 3 cycles then 0 -> btn stays 0000; 20 frame_tick pulses -> left_pos stays 208.
REQ-030 left_up=1 held -> btn[0]=1 on 6th edge; then 10 frame_tick pulses -> left_pos=168, right_pos=208.
REQ-031 right_down=1 held, 110 frame_tick pulses -> right_pos saturates at 416, never exceeds or wraps; left_up held 60 pulses -> left_pos saturates at 0.
REQ-032 left_up=left_down=1 held, 5 pulses -> left_pos unchanged; frame_tick held high 50 cycles with left_up only -> exactly one step (-4).
REQ-033 rst pulsed asynchronously between clk edges during movement -> positions 208 and btn 0000 before next edge; movement resumes only after re-debounce.
